// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed 7-segment driver: decodes 5-bit symbol codes, scans the
// digits at REFRESH_DIV clk per slot and applies a per-digit 1 Hz blink mask.
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd_in,
  input  logic [3:0]  blink_mask,
  input  logic        blink_sync,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] RCNT_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    CODE_BLANK = 5'h10;

  logic [RW-1:0] rcnt_reg;
  logic [1:0]    idx_reg;
  logic [BW-1:0] bcnt_reg;
  logic          phase_reg;
  logic [4:0]    shadow_reg [4];
  logic [3:0]    smask_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic          frame_tick_reg;

  logic          rwrap;
  logic          bwrap;
  logic          frame_latch;
  logic          dark;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'h00: s = 7'b0000001;
      5'h01: s = 7'b1001111;
      5'h02: s = 7'b0010010;
      5'h03: s = 7'b0000110;
      5'h04: s = 7'b1001100;
      5'h05: s = 7'b0100100;
      5'h06: s = 7'b0100000;
      5'h07: s = 7'b0001111;
      5'h08: s = 7'b0000000;
      5'h09: s = 7'b0000100;
      5'h0A: s = 7'b0001000;
      5'h0B: s = 7'b1100000;
      5'h0C: s = 7'b0110001;
      5'h0D: s = 7'b1000010;
      5'h0E: s = 7'b0110000;
      5'h0F: s = 7'b0111000;
      5'h11: s = 7'b1111110;
      5'h12: s = 7'b1110001;
      5'h13: s = 7'b1100010;
      5'h14: s = 7'b0011000;
      5'h15: s = 7'b1101010;
      5'h16: s = 7'b1111010;
      5'h17: s = 7'b1000001;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign rwrap       = (rcnt_reg == RCNT_MAX);
  assign bwrap       = (bcnt_reg == BCNT_MAX);
  assign frame_latch = rwrap && (idx_reg == 2'd3);

  // Scan position and refresh counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_reg <= '0;
      idx_reg  <= 2'd0;
    end else if (rwrap) begin
      rcnt_reg <= '0;
      idx_reg  <= idx_reg + 2'd1;
    end else begin
      rcnt_reg <= rcnt_reg + RW'(1);
    end
  end

  // Blink timer; a sync pulse overrides a coincident wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (blink_sync) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
    end else if (bwrap) begin
      bcnt_reg  <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      bcnt_reg  <= bcnt_reg + BW'(1);
    end
  end

  // Shadow copy of the display word, updated only at frame boundaries so a
  // frame never mixes old and new symbols.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          shadow_reg[gi] <= CODE_BLANK;
        else if (frame_latch)
          shadow_reg[gi] <= ssd_in[gi*5 +: 5];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smask_reg      <= 4'b0000;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_latch;
      if (frame_latch)
        smask_reg <= blink_mask;
    end
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    dark     = phase_reg && smask_reg[idx_reg];
    if (!dark) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = decode(shadow_reg[idx_reg]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= 4'b1111;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= 1'b1;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (REFRESH_DIV=4, BLINK_DIV=16) against a
// cycle-count model: scan slot, blink phase and frame latches derived by arithmetic.
module tb_ssd_scan_driver;

  localparam int R = 4;
  localparam int B = 16;
  localparam int FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] ssd_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blink_sync = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Model: n = clock edges since reset release, s = edge of last accepted sync.
  int         n = 0;
  int         s = 0;
  logic [4:0] sh [4];
  logic [3:0] smask = '0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_ft = 1'b0;

  ssd_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .ssd_in(ssd_in), .blink_mask(blink_mask),
    .blink_sync(blink_sync), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    logic [6:0] t [32];
    t[0]=7'b0000001;  t[1]=7'b1001111;  t[2]=7'b0010010;  t[3]=7'b0000110;
    t[4]=7'b1001100;  t[5]=7'b0100100;  t[6]=7'b0100000;  t[7]=7'b0001111;
    t[8]=7'b0000000;  t[9]=7'b0000100;  t[10]=7'b0001000; t[11]=7'b1100000;
    t[12]=7'b0110001; t[13]=7'b1000010; t[14]=7'b0110000; t[15]=7'b0111000;
    t[16]=7'b1111111; t[17]=7'b1111110; t[18]=7'b1110001; t[19]=7'b1100010;
    t[20]=7'b0011000; t[21]=7'b1101010; t[22]=7'b1111010; t[23]=7'b1000001;
    for (int k = 24; k < 32; k++) t[k] = 7'b1111111;
    return t[c];
  endfunction

  function automatic int slot_now();
    return (n / R) % 4;
  endfunction

  function automatic int phase_now();
    return ((n - s) / B) % 2;
  endfunction

  task automatic model_reset();
    n = 0; s = 0; smask = '0;
    for (int k = 0; k < 4; k++) sh[k] = 5'h10;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_ft = 1'b0;
  endtask

  // One clock: outputs after the edge reflect the model state before it.
  task automatic tick();
    int          idx;
    logic        dark;
    logic [3:0]  one;
    logic [3:0]  nan;
    logic [6:0]  nseg;
    idx  = slot_now();
    dark = (phase_now() == 1) && smask[idx];
    one  = 4'b0001 << idx;
    nan  = dark ? 4'hF : ~one;
    nseg = dark ? 7'h7F : ref_seg(sh[idx]);
    @(posedge clk);
    n++;
    if (blink_sync) s = n;
    exp_ft = (n % FRAME == 0);
    if (exp_ft) begin
      for (int k = 0; k < 4; k++) sh[k] = ssd_in[k*5 +: 5];
      smask = blink_mask;
    end
    exp_an = nan;
    exp_seg = nseg;
    #1;
  endtask

  task automatic test_reset();
    repeat (7) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got an=%b seg=%b dp=%b ft=%b want an=1111 seg=1111111 dp=1 ft=0",
               an, seg, dp, frame_tick);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL reset_scan n=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=1 ft=%b",
                 n, an, seg, dp, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  endtask

  task automatic test_digits();
    logic [3:0] lit_an  [4];
    logic [6:0] lit_seg [4];
    lit_an[0] = 4'b1110; lit_an[1] = 4'b1101; lit_an[2] = 4'b1011; lit_an[3] = 4'b0111;
    lit_seg[0] = 7'b1000010; lit_seg[1] = 7'b0100100;
    lit_seg[2] = 7'b1110001; lit_seg[3] = 7'b0110001;
    ssd_in = {5'h0C, 5'h12, 5'h05, 5'h0D};
    blink_mask = 4'b0000;
    for (int i = 0; i < FRAME && (n % FRAME != 0 || i == 0); i++) tick();
    while (n % FRAME != 0) tick();
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL digits_frame_tick n=%0d got %b want 1", n, frame_tick);
    end
    tick();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (an !== lit_an[d] || seg !== lit_seg[d]) begin
        errors++;
        $display("FAIL digits_cl5d slot=%0d got an=%b seg=%b want an=%b seg=%b",
                 d, an, seg, lit_an[d], lit_seg[d]);
      end
      repeat (R) tick();
    end
  endtask

  task automatic test_midframe();
    while (n % FRAME != 5) tick();
    ssd_in = {4{5'h11}};
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL midframe n=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                 n, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
  endtask

  task automatic test_blink();
    int budget;
    bit dark_seen;
    ssd_in = {5'h01, 5'h02, 5'h03, 5'h04};
    blink_mask = 4'b1000;
    dark_seen = 0;
    for (int i = 0; i < 6 * B; i++) begin
      tick();
      if (an == 4'hF) dark_seen = 1;
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL blink n=%0d got an=%b seg=%b ft=%b want an=%b seg=%b ft=%b",
                 n, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
    checks++;
    if (!dark_seen) begin
      errors++;
      $display("FAIL blink_dark_seen got 0 want 1");
    end
    budget = 200;
    while (!(phase_now() == 1 && slot_now() == 3) && budget > 0) begin
      tick(); budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL blink_find_dark got timeout want dark slot");
    end
    blink_sync = 1'b1;
    tick();
    blink_sync = 1'b0;
    for (int i = 0; i < 2 * B; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL blink_sync n=%0d got an=%b seg=%b want an=%b seg=%b",
                 n, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_blank_codes();
    blink_mask = 4'b0000;
    ssd_in = {5'h18, 5'h07, 5'h1F, 5'h17};
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL blank_codes n=%0d got an=%b seg=%b want an=%b seg=%b",
                 n, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_sync_wrap();
    blink_mask = 4'b1111;
    for (int rep = 0; rep < 3; rep++) begin
      while ((n - s) % B != B - 1) tick();
      blink_sync = 1'b1;
      tick();
      blink_sync = 0;
      for (int i = 0; i < B + 4; i++) begin
        tick();
        checks++;
        if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
          errors++;
          $display("FAIL sync_wrap rep=%0d n=%0d got an=%b seg=%b want an=%b seg=%b",
                   rep, n, an, seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ssd_in = 20'($urandom);
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
      blink_sync = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) begin
        blink_sync = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL random_reset got an=%b seg=%b dp=%b ft=%b want an=1111 seg=1111111 dp=1 ft=0",
                   an, seg, dp, frame_tick);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
      end
      tick();
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, 1'b1, exp_ft}) begin
        errors++;
        $display("FAIL random n=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=1 ft=%b",
                 n, an, seg, dp, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
    blink_sync = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_digits();
    test_midframe();
    test_blink();
    test_blank_codes();
    test_sync_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
